// File: rtl/tmr_triplet_lock_arbiter.sv
// tmr_triplet_lock_arbiter
//
// Purpose: round-robin arbiter that funnels NumIn operation-group pipelines
// into the single upstream port of a time-redundant voter. Once an input is
// granted, the grant is held until all three redundant copies of its ID have
// passed. This keeps copies of one item from interleaving with another group.
// A lost copy is covered by an idle timeout. The voter can extend the lock
// through lock_i.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-high
//   req_i      per-input valid
//   data_i     per-input payload
//   id_i       per-input redundancy ID
//   gnt_o      per-input ready (only the selected input can see gnt_i)
//   req_o      downstream valid (req_i of the selected input)
//   data_o     selected payload
//   id_o       selected ID
//   idx_o      selected input index
//   gnt_i      downstream ready
//   lock_i     voter asks the current input to stay granted
//   locked_o   arbiter is in LOCKED
//   timeout_o  one-cycle pulse on a timeout release
module tmr_triplet_lock_arbiter #(
    parameter  int NumIn       = 3,
    parameter  int DataWidth   = 8,
    parameter  int IdWidth     = 5,
    parameter  int LockTimeout = 5,
    localparam int IdxWidth    = $clog2(NumIn)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumIn-1:0]                    req_i,
    input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
    input  logic [NumIn-1:0][IdWidth-1:0]       id_i,
    output logic [NumIn-1:0]                    gnt_o,
    output logic                                req_o,
    output logic [DataWidth-1:0]                data_o,
    output logic [IdWidth-1:0]                  id_o,
    output logic [IdxWidth-1:0]                 idx_o,
    input  logic                                gnt_i,
    input  logic                                lock_i,
    output logic                                locked_o,
    output logic                                timeout_o
);

    localparam int TW = $clog2(LockTimeout + 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                state_q,    state_d;
    logic [IdxWidth-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [IdxWidth-1:0]   sel_q,      sel_d;
    logic [1:0]            cnt_q,      cnt_d;
    logic [TW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [IdWidth-1:0]    id_q,       id_d;
    logic                  hold_q,     hold_d;

    logic [IdxWidth-1:0]   sel;
    logic                  req_sel;
    logic                  hs;
    logic                  timeout;
    logic [NumIn-1:0]      gnt_vec;

    // First requesting input at or after ptr, wrapping; ptr when none request.
    // Walking offsets from high to low lets the smallest offset win.
    function automatic logic [IdxWidth-1:0] rr_pick(input logic [NumIn-1:0]  req,
                                                    input logic [IdxWidth-1:0] ptr);
        logic [IdxWidth-1:0] pick;
        int                  idx;
        pick = ptr;
        for (int k = NumIn - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NumIn;
            if (req[idx]) pick = IdxWidth'(idx);
        end
        return pick;
    endfunction

    // Selection: a locked input or a stalled IDLE offer stays put.
    always_comb begin
        sel = sel_q;
        if (state_q == IDLE && !hold_q) sel = rr_pick(req_i, rr_ptr_q);
    end

    assign req_sel = req_i[sel];
    assign hs      = req_sel & gnt_i;

    // A returning request on the locked input cancels a pending timeout.
    assign timeout = (state_q == LOCKED) && (idle_cnt_q == TW'(LockTimeout)) && !req_i[sel_q];

    always_comb begin
        gnt_vec      = '0;
        gnt_vec[sel] = gnt_i;
    end

    assign gnt_o     = rst_i ? '0 : gnt_vec;
    assign req_o     = req_sel & ~rst_i;
    assign data_o    = data_i[sel];
    assign id_o      = id_i[sel];
    assign idx_o     = sel;
    assign locked_o  = (state_q == LOCKED) & ~rst_i;
    assign timeout_o = timeout & ~rst_i;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        id_d       = id_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d    = LOCKED;
                    sel_d      = sel;
                    id_d       = id_i[sel];
                    cnt_d      = 2'd1;
                    idle_cnt_d = '0;
                    hold_d     = 1'b0;
                end else if (req_sel && !gnt_i) begin
                    hold_d = 1'b1;
                    sel_d  = sel;
                end else if (gnt_i) begin
                    // Downstream is ready again; a withdrawn offer is dropped.
                    hold_d = 1'b0;
                end
            end
            LOCKED: begin
                if (req_i[sel_q])                            idle_cnt_d = '0;
                else if (idle_cnt_q != TW'(LockTimeout))     idle_cnt_d = idle_cnt_q + 1'b1;
                if (hs) begin
                    if (id_i[sel_q] == id_q) begin
                        if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
                    end else begin
                        // A new ID on the same input starts a fresh triplet.
                        id_d  = id_i[sel_q];
                        cnt_d = 2'd1;
                    end
                end
                if (timeout || (cnt_d == 2'd3 && !lock_i)) begin
                    state_d    = IDLE;
                    rr_ptr_d   = (sel_q == IdxWidth'(NumIn - 1)) ? '0 : sel_q + 1'b1;
                    cnt_d      = 2'd0;
                    idle_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            sel_q      <= '0;
            cnt_q      <= 2'd0;
            idle_cnt_q <= '0;
            id_q       <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            id_q       <= id_d;
            hold_q     <= hold_d;
        end
    end

endmodule
